// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
//   Shared constants and helpers for the RGB565 -> luma ROI path.
//   - Y_COEF_R/G/B : BT.601 integer luma weights (sum = 256)
//   - GRAY_LAT     : cycles from an accepted input pixel to its output strobe
//   - CNT_W_DEFAULT: default width of the column/line counters
//   - PIX_W/GRAY_W : widths of the input pixel and output luma buses
// -----------------------------------------------------------------------------
package gray_pkg;

  localparam int unsigned Y_COEF_R      = 77;
  localparam int unsigned Y_COEF_G      = 150;
  localparam int unsigned Y_COEF_B      = 29;
  localparam int unsigned GRAY_LAT      = 3;
  localparam int          CNT_W_DEFAULT = 12;
  localparam int          PIX_W         = 16;
  localparam int          GRAY_W        = 8;

  // Widen a 5-bit channel to 8 bits by replicating its MSBs, so full scale
  // maps to 255 and zero stays zero.
  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  // Same for the 6-bit green channel.
  function automatic logic [7:0] expand6(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

endpackage

// File: rtl/rgb565_gray_roi_if.sv
// -----------------------------------------------------------------------------
// rgb565_gray_roi_if
//   Pixel-stream bundle around the luma/ROI stage.
//   in_*  : frame-qualified RGB565 stream from the capture stage
//           (in_vsync, in_href, in_valid, in_data[15:0])
//   out_* : grey-scale stream toward the processing stages
//           (out_vsync, out_href, out_valid, out_gray[7:0])
//   Modports:
//     master : the side that feeds pixels in and observes the result
//     slave  : the converter itself
// -----------------------------------------------------------------------------
interface rgb565_gray_roi_if
  import gray_pkg::*;
;
  logic              in_vsync;
  logic              in_href;
  logic              in_valid;
  logic [PIX_W-1:0]  in_data;
  logic              out_vsync;
  logic              out_href;
  logic              out_valid;
  logic [GRAY_W-1:0] out_gray;

  modport master (
    output in_vsync, in_href, in_valid, in_data,
    input  out_vsync, out_href, out_valid, out_gray
  );

  modport slave (
    input  in_vsync, in_href, in_valid, in_data,
    output out_vsync, out_href, out_valid, out_gray
  );

endinterface

// File: rtl/rgb565_luma_pipe.sv
// -----------------------------------------------------------------------------
// rgb565_luma_pipe
//   Three-stage RGB565 -> 8-bit luma pipeline with the frame sidebands
//   carried alongside, so the output strobe is exactly three cycles after
//   the accepted input pixel.
//     S1: expand channels to 8 bits, register pixel flags
//     S2: register the three weighted products
//     S3: sum, take the upper byte, gate with the arming flag
//   Ports:
//     cam_pclk, rst_n       clock, async active-low reset
//     armed                 frame_armed from the top; gates strobe and href
//     bin_thresh[7:0]       only with GRAY_BINARIZE_EN; threshold used at S3
//     in_vsync/in_href      raw frame sidebands
//     in_valid, in_data     pixel strobe and RGB565 data
//     in_roi, in_line_roi   pixel-in-ROI and line-in-ROI flags for this cycle
//     out_vsync/out_href    delayed sidebands (href gated by line ROI + armed)
//     out_valid, out_gray   ROI pixel strobe and luma (held between strobes)
//   Macro: GRAY_BINARIZE_EN replaces luma by 8'hFF / 8'h00 against bin_thresh.
// -----------------------------------------------------------------------------
module rgb565_luma_pipe
  import gray_pkg::*;
(
  input  logic              cam_pclk,
  input  logic              rst_n,
  input  logic              armed,
`ifdef GRAY_BINARIZE_EN
  input  logic [7:0]        bin_thresh,
`endif
  input  logic              in_vsync,
  input  logic              in_href,
  input  logic              in_valid,
  input  logic              in_roi,
  input  logic              in_line_roi,
  input  logic [PIX_W-1:0]  in_data,
  output logic              out_vsync,
  output logic              out_href,
  output logic              out_valid,
  output logic [GRAY_W-1:0] out_gray
);

  // S1
  logic       vs_1, hr_1, v_1, roi_1, lroi_1;
  logic [7:0] r8_1, g8_1, b8_1;
  // S2
  logic        vs_2, hr_2, v_2, roi_2, lroi_2;
  logic [15:0] prod_r_2, prod_g_2, prod_b_2;
  // S3 combinational
  logic [15:0]       sum;
  logic [GRAY_W-1:0] luma;
  logic [GRAY_W-1:0] gray_next;
  logic              pix_ok;

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_1   <= 1'b0;
      hr_1   <= 1'b0;
      v_1    <= 1'b0;
      roi_1  <= 1'b0;
      lroi_1 <= 1'b0;
      r8_1   <= '0;
      g8_1   <= '0;
      b8_1   <= '0;
    end else begin
      vs_1   <= in_vsync;
      hr_1   <= in_href;
      v_1    <= in_valid;
      roi_1  <= in_roi;
      lroi_1 <= in_line_roi;
      // Data only moves on a real pixel; idle cycles keep the datapath quiet.
      if (in_valid) begin
        r8_1 <= expand5(in_data[15:11]);
        g8_1 <= expand6(in_data[10:5]);
        b8_1 <= expand5(in_data[4:0]);
      end
    end
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_2     <= 1'b0;
      hr_2     <= 1'b0;
      v_2      <= 1'b0;
      roi_2    <= 1'b0;
      lroi_2   <= 1'b0;
      prod_r_2 <= '0;
      prod_g_2 <= '0;
      prod_b_2 <= '0;
    end else begin
      vs_2     <= vs_1;
      hr_2     <= hr_1;
      v_2      <= v_1;
      roi_2    <= roi_1;
      lroi_2   <= lroi_1;
      prod_r_2 <= 16'(Y_COEF_R) * {8'd0, r8_1};
      prod_g_2 <= 16'(Y_COEF_G) * {8'd0, g8_1};
      prod_b_2 <= 16'(Y_COEF_B) * {8'd0, b8_1};
    end
  end

  // Coefficients sum to 256, so the largest sum is 255*256 = 65280: no carry out.
  always_comb begin
    sum    = prod_r_2 + prod_g_2 + prod_b_2;
    luma   = GRAY_W'(sum >> 8);
    pix_ok = v_2 & roi_2 & armed;
`ifdef GRAY_BINARIZE_EN
    gray_next = (luma >= bin_thresh) ? 8'hFF : 8'h00;
`else
    gray_next = luma;
`endif
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      out_vsync <= 1'b0;
      out_href  <= 1'b0;
      out_valid <= 1'b0;
      out_gray  <= '0;
    end else begin
      out_vsync <= vs_2;
      out_href  <= hr_2 & lroi_2 & armed;
      out_valid <= pix_ok;
      // Downstream may sample out_gray outside the strobe; keep last ROI pixel.
      if (pix_ok) begin
        out_gray <= gray_next;
      end
    end
  end

endmodule

// File: rtl/rgb565_gray_roi.sv
// -----------------------------------------------------------------------------
// rgb565_gray_roi
//   Converts the capture stage's RGB565 stream to 8-bit luma and passes only
//   pixels inside a fixed rectangular region of interest.
//   Ports:
//     cam_pclk         pixel clock
//     rst_n            async active-low reset
//     bin_thresh[7:0]  only with GRAY_BINARIZE_EN: binarization threshold
//     px (slave)       in_vsync/in_href/in_valid/in_data in,
//                      out_vsync/out_href/out_valid/out_gray out
//   Parameters: CNT_W (counter width, saturating), ROI_X/Y_START/END
//   (inclusive bounds).
//   Macro: GRAY_BINARIZE_EN adds bin_thresh and a thresholded output.
//   Output is suppressed until the first frame start seen after reset, so a
//   frame interrupted by reset is never emitted partially.
// -----------------------------------------------------------------------------
module rgb565_gray_roi
  import gray_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int ROI_X_START = 0,
  parameter int ROI_X_END   = 639,
  parameter int ROI_Y_START = 0,
  parameter int ROI_Y_END   = 479
) (
  input  logic cam_pclk,
  input  logic rst_n,
`ifdef GRAY_BINARIZE_EN
  input  logic [7:0] bin_thresh,
`endif
  rgb565_gray_roi_if.slave px
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             vs_q, hr_q;
  logic             vs_rise, hr_fall;
  logic             frame_armed;
  logic [CNT_W-1:0] x_cnt, y_cnt;
  int               x_i, y_i;
  logic             line_roi, pix_roi;

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b0;
      hr_q <= 1'b0;
    end else begin
      vs_q <= px.in_vsync;
      hr_q <= px.in_href;
    end
  end

  assign vs_rise = px.in_vsync & ~vs_q;
  assign hr_fall = ~px.in_href & hr_q;

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_armed <= 1'b0;
    end else if (vs_rise) begin
      frame_armed <= 1'b1;
    end
  end

  // Frame start dominates line end and pixel strobes.
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
    end else if (vs_rise || hr_fall) begin
      x_cnt <= '0;
    end else if (px.in_valid && x_cnt != CNT_MAX) begin
      x_cnt <= x_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      y_cnt <= '0;
    end else if (vs_rise) begin
      y_cnt <= '0;
    end else if (hr_fall && y_cnt != CNT_MAX) begin
      y_cnt <= y_cnt + CNT_W'(1);
    end
  end

  // The pixel's position is the count before its own increment.  Signed
  // compare keeps a zero lower bound from turning into a constant test.
  always_comb begin
    x_i      = int'(x_cnt);
    y_i      = int'(y_cnt);
    line_roi = (y_i >= ROI_Y_START) && (y_i <= ROI_Y_END);
    pix_roi  = line_roi && (x_i >= ROI_X_START) && (x_i <= ROI_X_END);
  end

  rgb565_luma_pipe u_luma_pipe (
    .cam_pclk    (cam_pclk),
    .rst_n       (rst_n),
    .armed       (frame_armed),
`ifdef GRAY_BINARIZE_EN
    .bin_thresh  (bin_thresh),
`endif
    .in_vsync    (px.in_vsync),
    .in_href     (px.in_href),
    .in_valid    (px.in_valid),
    .in_roi      (pix_roi),
    .in_line_roi (line_roi),
    .in_data     (px.in_data),
    .out_vsync   (px.out_vsync),
    .out_href    (px.out_href),
    .out_valid   (px.out_valid),
    .out_gray    (px.out_gray)
  );

endmodule

// File: tb/tb_rgb565_gray_roi.sv
// -----------------------------------------------------------------------------
// tb_rgb565_gray_roi
//   Three instances share one stimulus stream:
//     dut 0 : default full-frame ROI
//     dut 1 : ROI x 2..5, y 1..2
//     dut 2 : CNT_W=4, ROI x 12..15, y 0..15 (column saturation)
//   A frame-level model tags pixels with their column/line, computes luma
//   arithmetically and predicts each output three cycles later.
// -----------------------------------------------------------------------------
module tb_rgb565_gray_roi;

  logic        cam_pclk = 1'b0;
  logic        rst_n;
  logic        vs, hr, v;
  logic [15:0] d;
  logic [7:0]  bin_thresh;

  always #5 cam_pclk = ~cam_pclk;

  rgb565_gray_roi_if if_a ();
  rgb565_gray_roi_if if_b ();
  rgb565_gray_roi_if if_c ();

  assign if_a.in_vsync = vs;  assign if_a.in_href = hr;
  assign if_a.in_valid = v;   assign if_a.in_data = d;
  assign if_b.in_vsync = vs;  assign if_b.in_href = hr;
  assign if_b.in_valid = v;   assign if_b.in_data = d;
  assign if_c.in_vsync = vs;  assign if_c.in_href = hr;
  assign if_c.in_valid = v;   assign if_c.in_data = d;

  rgb565_gray_roi dut_a (
    .cam_pclk   (cam_pclk),
    .rst_n      (rst_n),
`ifdef GRAY_BINARIZE_EN
    .bin_thresh (bin_thresh),
`endif
    .px         (if_a)
  );

  rgb565_gray_roi #(.ROI_X_START(2), .ROI_X_END(5), .ROI_Y_START(1), .ROI_Y_END(2)) dut_b (
    .cam_pclk   (cam_pclk),
    .rst_n      (rst_n),
`ifdef GRAY_BINARIZE_EN
    .bin_thresh (bin_thresh),
`endif
    .px         (if_b)
  );

  rgb565_gray_roi #(.CNT_W(4), .ROI_X_START(12), .ROI_X_END(15),
                    .ROI_Y_START(0), .ROI_Y_END(15)) dut_c (
    .cam_pclk   (cam_pclk),
    .rst_n      (rst_n),
`ifdef GRAY_BINARIZE_EN
    .bin_thresh (bin_thresh),
`endif
    .px         (if_c)
  );

  logic       o_vs[3], o_h[3], o_v[3];
  logic [7:0] o_g[3];
  assign o_vs[0] = if_a.out_vsync; assign o_h[0] = if_a.out_href;
  assign o_v[0]  = if_a.out_valid; assign o_g[0] = if_a.out_gray;
  assign o_vs[1] = if_b.out_vsync; assign o_h[1] = if_b.out_href;
  assign o_v[1]  = if_b.out_valid; assign o_g[1] = if_b.out_gray;
  assign o_vs[2] = if_c.out_vsync; assign o_h[2] = if_c.out_href;
  assign o_v[2]  = if_c.out_valid; assign o_g[2] = if_c.out_gray;

  int p_max[3] = '{4095, 4095, 15};
  int p_xs[3]  = '{0, 2, 12};
  int p_xe[3]  = '{639, 5, 15};
  int p_ys[3]  = '{0, 1, 0};
  int p_ye[3]  = '{479, 2, 15};

  typedef struct {
    bit vs;
    bit hr;
    bit v;
    int g;
  } ent_t;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // model state
  ent_t dl[3][3];
  int   gh[3];
  int   mx[3], my[3];
  bit   armed_m, pv, ph;

  // statistics for hand-computed expectations
  int   vcnt[3], hcnt[3], hrise[3], vscnt[3];
  bit   ph_o[3];
  int   cap_a[$], cap_b[$];
  int   first_a, t_first;

  logic [15:0] pix[$];

  function automatic int luma_of(input logic [15:0] p);
    int r, g, b, r8, g8, b8, y;
    r  = int'(p[15:11]);
    g  = int'(p[10:5]);
    b  = int'(p[4:0]);
    r8 = r * 8 + r / 4;
    g8 = g * 4 + g / 16;
    b8 = b * 8 + b / 4;
    y  = (77 * r8 + 150 * g8 + 29 * b8) / 256;
`ifdef GRAY_BINARIZE_EN
    y  = (y >= int'(bin_thresh)) ? 255 : 0;
`endif
    return y;
  endfunction

  task automatic clear_stats();
    for (int k = 0; k < 3; k++) begin
      vcnt[k] = 0; hcnt[k] = 0; hrise[k] = 0; vscnt[k] = 0;
    end
    cap_a.delete();
    cap_b.delete();
    first_a = -1;
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Model and per-cycle compare.
  initial begin
    ent_t e, x;
    bit vsr, hrf, xin, yin;
    forever begin
      @(posedge cam_pclk);
      #1;
      cyc++;
      if (!rst_n) begin
        armed_m = 0; pv = 0; ph = 0;
        for (int k = 0; k < 3; k++) begin
          mx[k] = 0; my[k] = 0; gh[k] = 0;
          for (int j = 0; j < 3; j++) dl[k][j] = '{0, 0, 0, 0};
          n_checks++;
          if (o_vs[k] !== 1'b0 || o_h[k] !== 1'b0 || o_v[k] !== 1'b0 || o_g[k] !== 8'd0) begin
            n_err++;
            $display("FAIL reset_outs dut%0d cyc=%0d got vs/hr/v/g=%b/%b/%b/%0d want 0/0/0/0",
                     k, cyc, o_vs[k], o_h[k], o_v[k], o_g[k]);
          end
        end
      end else begin
        vsr = vs && !pv;
        hrf = !hr && ph;
        if (vsr) armed_m = 1;
        for (int k = 0; k < 3; k++) begin
          yin  = (my[k] >= p_ys[k]) && (my[k] <= p_ye[k]);
          xin  = (mx[k] >= p_xs[k]) && (mx[k] <= p_xe[k]);
          e.vs = vs;
          e.hr = hr && yin && armed_m;
          e.v  = v && xin && yin && armed_m;
          e.g  = luma_of(d);
          dl[k][0] = dl[k][1];
          dl[k][1] = dl[k][2];
          dl[k][2] = e;
          x = dl[k][0];
          if (x.v) gh[k] = x.g;
          n_checks++;
          if (o_vs[k] !== x.vs || o_h[k] !== x.hr || o_v[k] !== x.v || int'(o_g[k]) != gh[k]) begin
            n_err++;
            $display("FAIL stream dut%0d cyc=%0d got vs/hr/v/g=%b/%b/%b/%0d want %0b/%0b/%0b/%0d",
                     k, cyc, o_vs[k], o_h[k], o_v[k], o_g[k], x.vs, x.hr, x.v, gh[k]);
          end
          if (vsr) begin
            mx[k] = 0; my[k] = 0;
          end else if (hrf) begin
            mx[k] = 0;
            if (my[k] < p_max[k]) my[k]++;
          end else if (v && mx[k] < p_max[k]) begin
            mx[k]++;
          end
          if (o_v[k]) vcnt[k]++;
          if (o_h[k]) hcnt[k]++;
          if (o_h[k] && !ph_o[k]) hrise[k]++;
          if (o_vs[k]) vscnt[k]++;
          ph_o[k] = o_h[k];
        end
        if (o_v[0]) begin
          cap_a.push_back(int'(o_g[0]));
          if (first_a < 0) first_a = cyc;
        end
        if (o_v[1]) cap_b.push_back(int'(o_g[1]));
        pv = vs;
        ph = hr;
      end
    end
  end

  task automatic idle(input int n);
    vs = 0; hr = 0; v = 0; d = '0;
    repeat (n) @(negedge cam_pclk);
  endtask

  task automatic vsync_pulse();
    vs = 1; hr = 0; v = 0; d = '0;
    repeat (2) @(negedge cam_pclk);
    idle(4);
  endtask

  task automatic line(input int npix);
    hr = 1;
    for (int i = 0; i < npix; i++) begin
      v = 1;
      d = (i < pix.size()) ? pix[i] : 16'(i);
      if (i == 0) t_first = cyc;
      @(negedge cam_pclk);
    end
    v = 0; d = '0; hr = 0;
    @(negedge cam_pclk);
    idle(3);
  endtask

  initial begin
    int exp_col[5];
    int exp_b[8];
    int ok;
    bin_thresh = 8'd100;
    rst_n = 1'b0;
    vs = 0; hr = 0; v = 0; d = '0;
    clear_stats();
    repeat (4) @(negedge cam_pclk);
    rst_n = 1'b1;
    idle(3);

    // No frame start yet: nothing may come out.
    clear_stats();
    pix.delete();
    line(16);
    idle(2);
    check_lit("unarmed_valid_a", vcnt[0] + vcnt[1] + vcnt[2], 0);
    check_lit("unarmed_href_a", hcnt[0] + hcnt[1] + hcnt[2], 0);

    // Arm, then the primary colours on line 0.
    clear_stats();
    vsync_pulse();
    check_lit("vsync_tracks_a", vscnt[0], 2);
    clear_stats();
    pix = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF, 16'h0000};
    line(5);
    idle(2);
`ifdef GRAY_BINARIZE_EN
    exp_col = '{0, 255, 0, 255, 0};
`else
    exp_col = '{76, 149, 28, 255, 0};
`endif
    check_lit("colour_count_a", cap_a.size(), 5);
    for (int i = 0; i < 5; i++) begin
      ok = (i < cap_a.size()) ? cap_a[i] : -1;
      check_lit($sformatf("colour_gray_a[%0d]", i), ok, exp_col[i]);
    end
    check_lit("latency_a", first_a - t_first, 3);
    check_lit("colour_none_b", vcnt[1], 0);

    // ROI window: 4 lines of 8 pixels, data = column index.
    vsync_pulse();
    clear_stats();
    pix.delete();
    repeat (4) line(8);
    idle(2);
`ifdef GRAY_BINARIZE_EN
    exp_b = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    exp_b = '{1, 2, 3, 4, 1, 2, 3, 4};
`endif
    check_lit("roi_count_b", cap_b.size(), 8);
    for (int i = 0; i < 8; i++) begin
      ok = (i < cap_b.size()) ? cap_b[i] : -1;
      check_lit($sformatf("roi_gray_b[%0d]", i), ok, exp_b[i]);
    end
    check_lit("roi_href_lines_b", hrise[1], 2);
    check_lit("roi_href_cycles_b", hcnt[1], 16);
    check_lit("full_count_a", vcnt[0], 32);
    check_lit("roi_none_c", vcnt[2], 0);

    // Saturating 4-bit column counter: pixels 12..19 all land in 12..15.
    vsync_pulse();
    clear_stats();
    line(20);
    idle(2);
    check_lit("sat_count_c", vcnt[2], 8);
    check_lit("sat_count_a", vcnt[0], 20);

    // Reset mid-line at x=100, then an unarmed line, then a fresh frame.
    vsync_pulse();
    pix.delete();
    for (int i = 0; i < 100; i++) pix.push_back(16'hFFFF);
    hr = 1;
    for (int i = 0; i < 100; i++) begin
      v = 1; d = pix[i];
      @(negedge cam_pclk);
    end
    rst_n = 1'b0;
    hr = 0; v = 0; d = '0;
    repeat (3) @(negedge cam_pclk);
    rst_n = 1'b1;
    idle(2);
    clear_stats();
    pix.delete();
    line(16);
    idle(2);
    check_lit("post_reset_valid_a", vcnt[0], 0);
    check_lit("post_reset_href_a", hcnt[0], 0);
    vsync_pulse();
    clear_stats();
    line(8);
    line(8);
    idle(2);
    check_lit("new_frame_count_b", vcnt[1], 4);
    check_lit("new_frame_count_a", vcnt[0], 16);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
